switch_bounce_emulator: RTL and testbench
=========================================

// Module: switch_bounce_emulator
// PURPOSE
//  Generates a mechanically realistic bouncing switch signal from a clean level command.
//  Drives the raw switch input of our debounce logic for board self-test and simulation.
//  On each commanded level change, sw_out chatters at pseudo-random (LFSR) intervals
//  for a fixed window, then settles to the commanded level. A bypass mode passes the
//  level straight through.
// PARAMETERS
//  TICK_M       100_000  clk cycles per bounce tick (1 ms at 100 MHz)
//  BOUNCE_TICKS 8        bounce window length in ticks (>=2)
//  GAP_BITS     2        LFSR bits used for the toggle gap; gap = lfsr[GAP_BITS-1:0]+1 ticks
//  LFSR_SEED    16'hACE1 initial LFSR value; 0 is replaced by 16'h0001
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  enable     in   1  1 = emulate bounce; 0 = bypass (sw_out follows level_in)
//  level_in   in   1  clean commanded switch level, synchronous to clk
//  sw_out     out  1  emulated raw switch output, registered
//  busy       out  1  high while in a BOUNCE state
//  toggle_cnt out  8  toggles emitted in current/last window, saturates at 255
// BEHAVIOUR
//  Reset values: sw_out=0, busy=0, toggle_cnt=0, state=IDLE_LO, LFSR=seed, prescaler=0.
//  Prescaler free-runs 0..TICK_M-1. tick=1 for one clk when count==TICK_M-1.
//  LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances on every tick.
//  States: IDLE_LO, BOUNCE_HI (heading to 1), IDLE_HI, BOUNCE_LO (heading to 0).
//  IDLE_LO and level_in=1 and enable -> BOUNCE_HI on the next edge:
//   win_cnt=0, gap_cnt=lfsr gap, toggle_cnt=0, sw_out toggles immediately (counts as 1 toggle).
//  IDLE_HI and level_in=0 is symmetric -> BOUNCE_LO.
//  In BOUNCE_x, on each tick:
//   win_cnt++; gap_cnt--.
//   If gap_cnt reaches 0 and the window is not done, sw_out toggles, toggle_cnt++, and gap reloads.
//  Window done (tick with win_cnt==BOUNCE_TICKS-1): sw_out is set to the target level,
//   state goes to IDLE_x. This has priority over a gap toggle on the same tick.
//  Settle latency: last entry edge + BOUNCE_TICKS ticks, independent of the gap values.
//  If level_in reverts to the old level mid-bounce, the FSM goes directly to the opposite
//   BOUNCE state on the next edge. The window restarts, toggle_cnt clears, and sw_out toggles.
//  busy = 1 exactly in the BOUNCE states (registered with state).
//  enable=0 from any state:
//   - next edge: state=IDLE_(level_in), sw_out=level_in, busy=0.
//   - 1-cycle pass-through after that. toggle_cnt holds its value.
//  enable rising while sw_out==level_in causes no bounce. A bounce starts only on a mismatch.
//  Reset mid-bounce: all state returns immediately to the reset values (async).
// STRUCTURE
//  switch_emu_pkg: state_t enum (IDLE_LO, BOUNCE_HI, IDLE_HI, BOUNCE_LO), LFSR_TAPS constant.
//  Sub-module: prescaler uses our existing mod_m_counter (M=TICK_M, max_tick -> tick).
//  LFSR, gap/window counters and FSM stay in this module.
// TESTING  (sim: TICK_M=4, BOUNCE_TICKS=8, GAP_BITS=2, LFSR_SEED=16'hACE1)
//  1. Assert reset for 3 clk, then release with level_in=0 -> sw_out=0, busy=0, toggle_cnt=0,
//     held for 100 clk.
//  2. enable=1, level_in 0->1 -> busy=1 next edge and sw_out toggles; sw_out=1 and busy=0
//     after 8 ticks (30-33 clk); toggle_cnt in 1..8.
//  3. enable=0, 3-clk level_in pulse -> sw_out is the same pulse delayed 1 clk;
//     busy stays 0; toggle_cnt unchanged.
//  4. level_in 0->1, back to 0 after 3 ticks -> enters BOUNCE_LO, window restarts;
//     final sw_out=0 exactly 8 ticks after the reversal.
//  5. Seed 0 vs seed 1 with identical stimulus -> identical sw_out traces;
//     the LFSR never reads 0.
//  6. Async reset asserted mid-bounce between clk edges -> sw_out=0 and busy=0 immediately;
//     state=IDLE_LO.

Source files
------------

// File: rtl/switch_emu_pkg.sv
// Shared types and LFSR helper for the switch bounce emulator.
package switch_emu_pkg;

    typedef enum logic [1:0] {
        IDLE_LO   = 2'd0,
        BOUNCE_HI = 2'd1,
        IDLE_HI   = 2'd2,
        BOUNCE_LO = 2'd3
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/switch_bounce_emulator_if.sv
// Command/observation bundle between a stimulus source and the bounce emulator.
interface switch_bounce_emulator_if;

    logic       enable;
    logic       level_in;
    logic       sw_out;
    logic       busy;
    logic [7:0] toggle_cnt;

    modport master (
        output enable,
        output level_in,
        input  sw_out,
        input  busy,
        input  toggle_cnt
    );

    modport slave (
        input  enable,
        input  level_in,
        output sw_out,
        output busy,
        output toggle_cnt
    );

endinterface

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with a one-cycle pulse on the terminal count.
module mod_m_counter #(
    parameter int M = 10,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    logic [N-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == N'(M - 1)) begin
            count <= '0;
        end else begin
            count <= count + N'(1);
        end
    end

    assign max_tick = (count == N'(M - 1));

endmodule

// File: rtl/switch_bounce_emulator.sv
// Emulates a mechanically bouncing switch: LFSR-spaced chatter for a fixed tick window,
// then settles on the commanded level; enable=0 bypasses straight to level_in.
module switch_bounce_emulator
    import switch_emu_pkg::*;
#(
    parameter int          TICK_M       = 100_000,
    parameter int          BOUNCE_TICKS = 8,
    parameter int          GAP_BITS     = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    switch_bounce_emulator_if.slave sw_if
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          WIN_W    = $clog2(BOUNCE_TICKS);
    localparam int          GAP_W    = GAP_BITS + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_TICKS - 1);

    logic             tick;
    logic             restart;
    state_t           state, state_next;
    logic [15:0]      lfsr;
    logic [WIN_W-1:0] win_cnt, win_next;
    logic [GAP_W-1:0] gap_cnt, gap_next, gap_load;
    logic             sw_reg, sw_next;
    logic             busy_reg;
    logic [7:0]       tcnt, tcnt_next;

    mod_m_counter #(.M(TICK_M)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .max_tick (tick)
    );

    assign gap_load = {1'b0, lfsr[GAP_BITS-1:0]} + GAP_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE_LO;
            sw_reg   <= 1'b0;
            busy_reg <= 1'b0;
            tcnt     <= 8'd0;
            win_cnt  <= '0;
            gap_cnt  <= '0;
            lfsr     <= SEED;
        end else begin
            state    <= state_next;
            sw_reg   <= sw_next;
            busy_reg <= (state_next == BOUNCE_HI) || (state_next == BOUNCE_LO);
            tcnt     <= tcnt_next;
            win_cnt  <= win_next;
            gap_cnt  <= gap_next;
            if (tick) begin
                lfsr <= lfsr_next(lfsr);
            end
        end
    end

    // A level mismatch (from idle or mid-bounce) restarts the window toward level_in;
    // the window end wins over a gap toggle on the same tick.
    always_comb begin
        state_next = state;
        sw_next    = sw_reg;
        tcnt_next  = tcnt;
        win_next   = win_cnt;
        gap_next   = gap_cnt;
        restart    = 1'b0;
        if (!sw_if.enable) begin
            state_next = sw_if.level_in ? IDLE_HI : IDLE_LO;
            sw_next    = sw_if.level_in;
        end else begin
            case (state)
                IDLE_LO, BOUNCE_LO: restart = sw_if.level_in;
                IDLE_HI, BOUNCE_HI: restart = !sw_if.level_in;
                default:            restart = 1'b0;
            endcase
            if (restart) begin
                state_next = sw_if.level_in ? BOUNCE_HI : BOUNCE_LO;
                win_next   = '0;
                gap_next   = gap_load;
                tcnt_next  = 8'd1;
                sw_next    = ~sw_reg;
            end else if (tick && ((state == BOUNCE_HI) || (state == BOUNCE_LO))) begin
                if (win_cnt == WIN_LAST) begin
                    state_next = (state == BOUNCE_HI) ? IDLE_HI : IDLE_LO;
                    sw_next    = (state == BOUNCE_HI);
                end else begin
                    win_next = win_cnt + WIN_W'(1);
                    gap_next = gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        sw_next   = ~sw_reg;
                        tcnt_next = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
                        gap_next  = gap_load;
                    end
                end
            end
        end
    end

    assign sw_if.sw_out     = sw_reg;
    assign sw_if.busy       = busy_reg;
    assign sw_if.toggle_cnt = tcnt;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Randomized scoreboard bench: a behavioural bounce model predicts every cycle's outputs
// for seeds ACE1 and 1; a seed-0 instance must track the seed-1 prediction exactly.
module tb_switch_bounce_emulator;
    import switch_emu_pkg::*;

    localparam int TICK_M       = 4;
    localparam int BOUNCE_TICKS = 8;
    localparam int GAP_BITS     = 2;

    logic clk;
    logic reset;
    logic en_drv;
    logic lvl_drv;

    int checks = 0;
    int errors = 0;

    switch_bounce_emulator_if bus_a ();
    switch_bounce_emulator_if bus_z ();
    switch_bounce_emulator_if bus_o ();

    assign bus_a.enable   = en_drv;
    assign bus_a.level_in = lvl_drv;
    assign bus_z.enable   = en_drv;
    assign bus_z.level_in = lvl_drv;
    assign bus_o.enable   = en_drv;
    assign bus_o.level_in = lvl_drv;

    switch_bounce_emulator #(.TICK_M(TICK_M), .BOUNCE_TICKS(BOUNCE_TICKS), .GAP_BITS(GAP_BITS),
                             .LFSR_SEED(16'hACE1)) u_dut (.clk(clk), .reset(reset), .sw_if(bus_a));
    switch_bounce_emulator #(.TICK_M(TICK_M), .BOUNCE_TICKS(BOUNCE_TICKS), .GAP_BITS(GAP_BITS),
                             .LFSR_SEED(16'h0000)) u_dut_s0 (.clk(clk), .reset(reset), .sw_if(bus_z));
    switch_bounce_emulator #(.TICK_M(TICK_M), .BOUNCE_TICKS(BOUNCE_TICKS), .GAP_BITS(GAP_BITS),
                             .LFSR_SEED(16'h0001)) u_dut_s1 (.clk(clk), .reset(reset), .sw_if(bus_o));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       sw0;
        logic       busy0;
        logic [7:0] cnt0;
        logic       sw1;
        logic       busy1;
        logic [7:0] cnt1;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: index 0 uses seed ACE1, index 1 uses seed 1 (what seed 0 must become).
    int presc;
    int m_lfsr[2];
    bit m_bouncing[2];
    bit m_target[2];
    bit m_out[2];
    int m_elapsed[2];
    int m_gap_left[2];
    int m_toggles[2];

    function automatic int next_lfsr(input int v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) | fb) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        presc    = 0;
        m_lfsr[0] = 32'hACE1;
        m_lfsr[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_bouncing[i] = 0;
            m_target[i]   = 0;
            m_out[i]      = 0;
            m_elapsed[i]  = 0;
            m_gap_left[i] = 0;
            m_toggles[i]  = 0;
        end
    endtask

    task automatic model_step(input bit en, input bit lvl);
        bit tick;
        int gap;
        tick  = (presc == TICK_M - 1);
        presc = tick ? 0 : presc + 1;
        for (int i = 0; i < 2; i++) begin
            gap = (m_lfsr[i] % (1 << GAP_BITS)) + 1;
            if (!en) begin
                m_bouncing[i] = 0;
                m_target[i]   = lvl;
                m_out[i]      = lvl;
            end else if (lvl != m_target[i]) begin
                m_bouncing[i] = 1;
                m_target[i]   = lvl;
                m_elapsed[i]  = 0;
                m_gap_left[i] = gap;
                m_toggles[i]  = 1;
                m_out[i]      = !m_out[i];
            end else if (m_bouncing[i] && tick) begin
                m_elapsed[i]++;
                if (m_elapsed[i] == BOUNCE_TICKS) begin
                    m_bouncing[i] = 0;
                    m_out[i]      = m_target[i];
                end else begin
                    m_gap_left[i]--;
                    if (m_gap_left[i] == 0) begin
                        m_out[i]      = !m_out[i];
                        m_toggles[i]  = (m_toggles[i] < 255) ? m_toggles[i] + 1 : 255;
                        m_gap_left[i] = gap;
                    end
                end
            end
            if (tick) m_lfsr[i] = next_lfsr(m_lfsr[i]);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (reset) model_reset();
        else model_step(en_drv, lvl_drv);
        e.sw0   = m_out[0];
        e.busy0 = m_bouncing[0];
        e.cnt0  = 8'(m_toggles[0]);
        e.sw1   = m_out[1];
        e.busy1 = m_bouncing[1];
        e.cnt1  = 8'(m_toggles[1]);
        exp_q.push_back(e);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d at %0t", name, actual, lo, hi, $time);
        end
    endtask

    // Monitor: every negedge pops the prediction made at the preceding posedge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("sw_out_ace1", 32'(bus_a.sw_out), 32'(e.sw0));
            check_output("busy_ace1", 32'(bus_a.busy), 32'(e.busy0));
            check_output("toggle_cnt_ace1", 32'(bus_a.toggle_cnt), 32'(e.cnt0));
            check_output("sw_out_seed0", 32'(bus_z.sw_out), 32'(e.sw1));
            check_output("busy_seed0", 32'(bus_z.busy), 32'(e.busy1));
            check_output("toggle_cnt_seed0", 32'(bus_z.toggle_cnt), 32'(e.cnt1));
            check_output("sw_out_seed1", 32'(bus_o.sw_out), 32'(e.sw1));
            check_output("toggle_cnt_seed1", 32'(bus_o.toggle_cnt), 32'(e.cnt1));
            check_output("lfsr_seed0_nonzero", 32'(u_dut_s0.lfsr != 16'h0000), 32'd1);
        end
    end

    task automatic apply_stimulus(input logic en, input logic lvl, input int cycles);
        en_drv  = en;
        lvl_drv = lvl;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int settle;
        reset   = 1'b1;
        en_drv  = 1'b0;
        lvl_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");

        apply_stimulus(1'b1, 1'b0, 100);

        // First bounce: settle edge must land 30..33 edges after the command.
        en_drv  = 1'b1;
        lvl_drv = 1'b1;
        settle  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.busy === 1'b0) begin
                settle = i;
                break;
            end
        end
        check_range("settle_latency", settle, 30, 33);
        check_output("settled_sw_out", 32'(bus_a.sw_out), 32'd1);
        check_range("first_window_toggles", int'(bus_a.toggle_cnt), 1, 8);
        apply_stimulus(1'b1, 1'b1, 10);

        $display("[TB] bypass pulse");
        apply_stimulus(1'b0, 1'b0, 5);
        apply_stimulus(1'b0, 1'b1, 3);
        apply_stimulus(1'b0, 1'b0, 6);

        $display("[TB] reversal mid-bounce");
        apply_stimulus(1'b1, 1'b1, 3 * TICK_M);
        apply_stimulus(1'b1, 1'b0, 40);

        $display("[TB] randomized phase");
        for (int k = 0; k < 60; k++) begin
            apply_stimulus(($urandom_range(7, 0) != 0), 1'($urandom_range(1, 0)),
                           $urandom_range(60, 1));
        end

        $display("[TB] async reset mid-bounce");
        apply_stimulus(1'b1, 1'b0, 45);
        apply_stimulus(1'b1, 1'b1, 10);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("async_reset_sw_out", 32'(bus_a.sw_out), 32'd0);
        check_output("async_reset_busy", 32'(bus_a.busy), 32'd0);
        check_output("async_reset_toggle_cnt", 32'(bus_a.toggle_cnt), 32'd0);
        check_output("async_reset_state", 32'(u_dut.state), 32'(IDLE_LO));
        en_drv  = 1'b0;
        lvl_drv = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 5);
        apply_stimulus(1'b1, 1'b1, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
